// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scanner.
// Segment patterns are active-low, ordered [6]=a .. [0]=g.
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } st_t;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [3:0] an_sel(
    input logic [1:0] i
  );
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

endpackage

// File: rtl/seg7_bcd_dec.sv
// seg7_bcd_dec: BCD nibble to active-low a..g pattern.
// Non-decimal nibbles (10..15) turn every segment off.
module seg7_bcd_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  // Pure lookup; codes above 9 fall to the blank pattern.
  always_comb begin
    pat = SEG_OFF;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode scan with blanking gaps.
// Define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        ready,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam logic [15:0] DLIM = 16'(DIGIT_TICKS - 1);
  localparam logic [15:0] BLIM = 16'(BLANK_TICKS - 1);

  st_t         st, st_n;
  logic [1:0]  idx, idx_n;
  logic [15:0] cnt, cnt_n;

  logic [15:0] disp, disp_n;
  logic [3:0]  ddp, ddp_n;
  logic [15:0] pend;
  logic [3:0]  pdp;
  logic        pend_v, pend_v_n;

  logic        ready_q;
  logic [7:0]  seg_q, seg_n;
  logic [3:0]  an_q, an_n;

  logic        to_blank;
  logic        bnd;
  logic        xfer;
  logic        accept;
  logic [3:0]  nib;
  logic        lz;
  logic [6:0]  dec_pat;

  // Phase sequencing: BLANK -> ON -> BLANK with digit advance.
  always_comb begin
    st_n  = st;
    idx_n = idx;
    cnt_n = cnt + 16'd1;
    unique case (1'b1)
      (st == ST_BLANK): begin
        if (cnt == BLIM) begin
          st_n  = ST_ON;
          cnt_n = '0;
        end
      end
      (st == ST_ON): begin
        if (cnt == DLIM) begin
          st_n  = ST_BLANK;
          idx_n = idx + 2'd1;
          cnt_n = '0;
        end
      end
      default: ;
    endcase
  end

  // Handshake and frame-boundary transfer of pending data.
  always_comb begin
    to_blank = (st == ST_ON) && (cnt == DLIM);
    bnd      = to_blank && (idx == 2'd3);
    xfer     = bnd && pend_v;
    accept   = load && ready_q;
    disp_n   = xfer ? pend : disp;
    ddp_n    = xfer ? pdp : ddp;
    pend_v_n = pend_v;
    if (accept) begin
      pend_v_n = 1'b1;
    end else if (xfer) begin
      pend_v_n = 1'b0;
    end
  end

  // Select the nibble for the digit about to be scanned.
  always_comb begin
    nib = disp_n[3:0];
    unique case (idx_n)
      2'd0: nib = disp_n[3:0];
      2'd1: nib = disp_n[7:4];
      2'd2: nib = disp_n[11:8];
      2'd3: nib = disp_n[15:12];
      default: nib = disp_n[3:0];
    endcase
  end

`ifdef SEG7_SCAN_LZB_EN
  // Blank a digit when it and all higher digits are zero.
  always_comb begin
    lz = 1'b0;
    unique case (idx_n)
      2'd0: lz = 1'b0;
      2'd1: lz = (disp_n[15:4] == 12'h000);
      2'd2: lz = (disp_n[15:8] == 8'h00);
      2'd3: lz = (disp_n[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase
  end
`else
  assign lz = 1'b0;
`endif

  seg7_bcd_dec u_dec (
    .nib (nib),
    .pat (dec_pat)
  );

  // Next segment byte and anode pattern.
  always_comb begin
    seg_n = {(lz ? SEG_OFF : dec_pat), ~ddp_n[idx_n]};
    an_n  = (st_n == ST_ON) ? an_sel(idx_n) : AN_OFF;
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_BLANK;
      idx     <= 2'd0;
      cnt     <= '0;
      disp    <= '0;
      ddp     <= '0;
      pend    <= '0;
      pdp     <= '0;
      pend_v  <= 1'b0;
      ready_q <= 1'b1;
      seg_q   <= 8'hFF;
      an_q    <= AN_OFF;
    end else begin
      st      <= st_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      disp    <= disp_n;
      ddp     <= ddp_n;
      pend_v  <= pend_v_n;
      ready_q <= ~pend_v_n;
      an_q    <= an_n;
      if (accept) begin
        pend <= digits_in;
        pdp  <= dp_in;
      end
      if (to_blank) begin
        seg_q <= seg_n;
      end
    end
  end

  assign ready = ready_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: checks scan timing, decode and load handshake
// against a schedule model derived from edge counts.
module tb_seg7_scan_ctrl;

  localparam int DT    = 4;
  localparam int BT    = 2;
  localparam int SLOT  = DT + BT;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] TBL [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        ready;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;

  int          n;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pv;
  logic [7:0]  m_seg;
  bit          armed = 0;
  logic        r_load;
  logic [15:0] r_d;
  logic [3:0]  r_dp;

  seg7_scan_ctrl #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .ready     (ready),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, n);
    end
  endtask

  function automatic logic [7:0] pat(input logic [15:0] d,
                                     input logic [3:0] dp,
                                     input int i);
    logic [15:0] up;
    logic [3:0]  nb;
    logic [6:0]  s;
    up = d >> (4 * i);
    nb = up[3:0];
    s  = (nb < 4'd10) ? TBL[nb] : 7'h7F;
`ifdef SEG7_SCAN_LZB_EN
    if (i > 0 && up == 16'h0) s = 7'h7F;
`endif
    return {s, ~dp[i]};
  endfunction

  initial begin : cmp
    bit          acc;
    int          k;
    logic [3:0]  one;
    logic [3:0]  exp_an;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = 0;
        m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0;
        m_pv = 0; m_seg = 8'hFF; armed = 1;
        chk("rst_an", {12'h0, an}, 16'hF);
        chk("rst_seg", {8'h0, seg}, 16'hFF);
        chk("rst_ready", {15'h0, ready}, 16'h1);
      end else if (armed) begin
        n++;
        acc = r_load && !m_pv;
        if (n % FRAME == 0 && m_pv) begin
          m_disp = m_pend; m_ddp = m_pdp; m_pv = 0;
        end
        if (acc) begin
          m_pend = r_d; m_pdp = r_dp; m_pv = 1;
        end
        k = (n / SLOT) % 4;
        if (n % SLOT == 0) m_seg = pat(m_disp, m_ddp, k);
        one = 4'b0001;
        exp_an = (n % SLOT >= BT) ? ~(one << k) : 4'hF;
        chk("an", {12'h0, an}, {12'h0, exp_an});
        chk("seg", {8'h0, seg}, {8'h0, m_seg});
        chk("ready", {15'h0, ready}, {15'h0, !m_pv});
        chk("an_onehot", 16'($countones(~an) <= 1), 16'h1);
      end
      r_load = load;
      r_d    = digits_in;
      r_dp   = dp_in;
    end
  end

  task automatic go(input int t);
    repeat (t - e) @(posedge clk);
    #1;
    e = t;
  endtask

  task automatic setld(input logic [15:0] d, input logic [3:0] dp);
    digits_in = d;
    dp_in     = dp;
    load      = 1'b1;
  endtask

  initial begin : stim
    @(negedge clk);
    #2 rst_n = 1'b1;
    e = 0;
    go(1);  chk("lit_an_e1", {12'h0, an}, 16'hF);
    go(2);  chk("lit_an_e2", {12'h0, an}, 16'hE);
            chk("lit_seg_e2", {8'h0, seg}, 16'hFF);
            setld(16'h1234, 4'b0100);
    go(3);  load = 1'b0;
            chk("lit_rdy_e3", {15'h0, ready}, 16'h0);
    go(6);  chk("lit_an_e6", {12'h0, an}, 16'hF);
    go(8);  chk("lit_an_e8", {12'h0, an}, 16'hD);
    go(9);  setld(16'h9999, 4'hF);
    go(10); load = 1'b0;
            chk("lit_rdy_e10", {15'h0, ready}, 16'h0);
    go(24); chk("lit_rdy_e24", {15'h0, ready}, 16'h1);
            chk("lit_seg_e24", {8'h0, seg}, 16'h99);
    go(26); chk("lit_an_d0", {12'h0, an}, 16'hE);
            chk("lit_seg_d0", {8'h0, seg}, 16'h99);
    go(32); chk("lit_an_d1", {12'h0, an}, 16'hD);
            chk("lit_seg_d1", {8'h0, seg}, 16'h0D);
    go(38); chk("lit_an_d2", {12'h0, an}, 16'hB);
            chk("lit_seg_d2", {8'h0, seg}, 16'h24);
    go(44); chk("lit_an_d3", {12'h0, an}, 16'h7);
            chk("lit_seg_d3", {8'h0, seg}, 16'h9F);
    go(46); setld(16'h0C00, 4'b0000);
    go(47); load = 1'b0;
            chk("lit_rdy_e47", {15'h0, ready}, 16'h0);
    go(48); chk("lit_rdy_e48", {15'h0, ready}, 16'h1);
            chk("lit_seg_e48", {8'h0, seg}, 16'h03);
    go(62); chk("lit_an_c", {12'h0, an}, 16'hB);
            chk("lit_seg_c", {8'h0, seg}, 16'hFF);
    go(71); setld(16'h5678, 4'b0001);
    go(72); load = 1'b0;
            chk("lit_rdy_e72", {15'h0, ready}, 16'h0);
    go(95); chk("lit_rdy_e95", {15'h0, ready}, 16'h0);
    go(96); chk("lit_rdy_e96", {15'h0, ready}, 16'h1);
            chk("lit_seg_e96", {8'h0, seg}, 16'h00);
            setld(16'h0050, 4'b0000);
    go(97); load = 1'b0;
    go(122); chk("lit_seg_z0", {8'h0, seg}, 16'h03);
    go(128); chk("lit_seg_z1", {8'h0, seg}, 16'h49);
`ifdef SEG7_SCAN_LZB_EN
    go(134); chk("lit_seg_z2", {8'h0, seg}, 16'hFF);
    go(140); chk("lit_seg_z3", {8'h0, seg}, 16'hFF);
`else
    go(134); chk("lit_seg_z2", {8'h0, seg}, 16'h03);
    go(140); chk("lit_seg_z3", {8'h0, seg}, 16'h03);
`endif
            setld(16'h1111, 4'hF);
    go(141); load = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("lit_arst_an", {12'h0, an}, 16'hF);
            chk("lit_arst_seg", {8'h0, seg}, 16'hFF);
            chk("lit_arst_rdy", {15'h0, ready}, 16'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    e = 0;
    go(1);  chk("lit_rdy_post", {15'h0, ready}, 16'h1);
    go(26); chk("lit_seg_post", {8'h0, seg}, 16'h03);
    go(50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
